spmv_network_node: RTL and testbench
====================================

Name: spmv_network_node

Overview:
- Registered, parametrised two-lane merge node for the SpMV reduction network.
- Each cycle it compares the ids on its two input lanes.
  - Equal ids: the values are summed and the sum is emitted on the lane facing the network centre.
  - Different ids: each lane passes through unchanged.
- Each output lane has its own one-entry output register and independent ready/valid handshake, so nodes chain without long combinational ready paths through the values.
- A saturating merge counter supports performance profiling.

Parameters:
- ID_WIDTH, 16: width of row id on both lanes.
- VAL_WIDTH, 32: input value width, signed two's complement.
- GROW, 1: extra output bits; OUT_WIDTH = VAL_WIDTH + GROW.
- SATURATE, 0: if 1 and GROW = 0, a merged sum clamps to the signed min/max instead of wrapping.
- LOCATION, 3: index of this node within the network row.
- PARALLELISM, 50: number of nodes in the row.
- CNT_WIDTH, 16: width of the merge counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- in_a_valid, in, 1: lane A input valid.
- in_a_ready, out, 1: lane A input ready.
- in_a_id, in, ID_WIDTH: lane A row id.
- in_a_val, in, VAL_WIDTH: lane A value.
- in_b_valid, in_b_ready, in_b_id, in_b_val: lane B, same directions and widths as lane A.
- out_a_valid, out, 1: lane A output valid.
- out_a_ready, in, 1: lane A downstream ready.
- out_a_id, out, ID_WIDTH: lane A output id.
- out_a_val, out, OUT_WIDTH: lane A output value.
- out_b_valid, out_b_ready, out_b_id, out_b_val: lane B, same as lane A output.
- merge_clr, in, 1: synchronous clear of the merge counter.
- merge_cnt, out, CNT_WIDTH: number of merges performed, saturating.

Behaviour:
- TOWARDS_CENTER = (LOCATION >= PARALLELISM/2), integer division, elaboration constant.
  - TARGET = A if TOWARDS_CENTER, else B.
- Output registers: per lane X, registers vX, idX, valX.
  - canX = !vX || out_X_ready.
  - out_X_valid = vX; out_X_id = idX; out_X_val = valX.
- Merge condition: match = in_a_valid && in_b_valid && (in_a_id == in_b_id).
- When match = 1:
  - in_a_ready = in_b_ready = canTARGET. Both lanes are consumed together or not at all.
  - On a transfer, the TARGET register loads id = in_a_id and val = sext(in_a_val) + sext(in_b_val) at OUT_WIDTH.
    - If SATURATE=1 and GROW=0, the sum is clamped on overflow.
  - The non-target register takes no new data. It may still drain if out_X_ready is high.
  - merge_cnt increments, saturating at all-ones.
- When match = 0, the lanes are independent:
  - in_X_ready = canX.
  - On a transfer, register X loads in_X_id and sext(in_X_val).
- Ready depends on valid and id only through match. No input ready depends on the input value.
- Register update: if a load occurs, vX = 1. Otherwise, if out_X_ready, vX = 0. Otherwise vX holds.
- Latency: 1 cycle from accepted input to out valid.
- Throughput: 1 item per lane per cycle when downstream is ready.
- Backpressure:
  - A stalled out_X (vX=1, out_X_ready=0) holds its id and val stable.
  - A stalled out_X deasserts in_X_ready.
  - In match, a stalled TARGET stalls both inputs.
- Simultaneous drain and load in the same cycle is allowed and keeps vX = 1.
- Counter precedence: merge_clr has priority over a simultaneous merge; the result is 0.
- Reset:
  - All vX = 0, idX = 0, valX = 0, merge_cnt = 0.
  - Any in-flight register contents are discarded.
  - in_X_ready is high in the cycle after reset deasserts.
- Ids are never altered. A non-merge path never changes the value beyond sign extension.

Decomposition:
- spmv_pkg holds:
  - the function towards_center(location, parallelism);
  - the function sat_add(a, b, width).
- Sub-module spmv_out_reg: a one-entry ready/valid register with a load port and can-load output. It is instantiated twice.

Test Plan:
1. Merge: LOCATION=30, PARALLELISM=50; A=(id 7, val 5), B=(id 7, val -3), both readies high -> next cycle out_a = (7, 2) valid, out_b not valid, merge_cnt = 1.
2. Merge toward B: LOCATION=3; A=(4, 10), B=(4, 20) -> out_b = (4, 30), out_a not valid.
3. Pass-through: A=(1, 100), B=(2, -1) -> out_a = (1, 100), out_b = (2, -1) sign-extended, merge_cnt unchanged.
4. Backpressure, divergent: out_b_ready=0 with vB=1 and ids differing -> in_b_ready=0, in_a_ready=1; lane A streams 3 items while out_b holds its id and val stable.
5. Backpressure, merge: ids match, TARGET=A and out_a stalled -> both readies low, no transfer, merge_cnt stable.
6. Saturation and counter: GROW=0, SATURATE=1, VAL_WIDTH=8; A=(9, 100), B=(9, 100) -> out val = 127. Also merge_clr together with a merge -> merge_cnt = 0.
7. Reset mid-stream: rst_n low with both registers valid -> next cycle all valids 0 and merge_cnt = 0.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared helpers for the SpMV reduction network: lane-direction selection and
// a width-generic saturating signed add.
package spmv_pkg;

  localparam int MAX_W = 64;

  // Nodes in the upper half of the row push merged sums toward lane A.
  function automatic logic towards_center(input int location, input int parallelism);
    return location >= (parallelism / 2);
  endfunction

  // a and b arrive sign-extended to MAX_W; the result is clamped to the signed
  // range of 'width' bits and returned sign-extended to MAX_W.
  function automatic logic signed [MAX_W-1:0] sat_add(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b,
    input int                      width
  );
    logic signed [MAX_W:0] sum;
    logic signed [MAX_W:0] max_v;
    logic signed [MAX_W:0] min_v;
    sum   = {a[MAX_W-1], a} + {b[MAX_W-1], b};
    max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
    min_v = -max_v - 65'sd1;
    if (sum > max_v) begin
      return max_v[MAX_W-1:0];
    end else if (sum < min_v) begin
      return min_v[MAX_W-1:0];
    end
    return sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/spmv_out_reg.sv
// One-entry output register for a single lane of the merge node.
module spmv_out_reg #(
  parameter int ID_WIDTH  = 16,
  parameter int VAL_WIDTH = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ID_WIDTH-1:0]  load_id,
  input  logic [VAL_WIDTH-1:0] load_val,
  input  logic                 out_ready,
  output logic                 can_load,
  output logic                 out_valid,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic [VAL_WIDTH-1:0] out_val
);

  // Handshake: a beat moves when valid && ready are both high on a rising edge;
  // valid never depends on ready, and id/val stay stable while valid && !ready.
  // The parent only asserts load when can_load is high.
  logic                 v_q, v_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [VAL_WIDTH-1:0] val_q, val_d;

  always_comb begin
    can_load = !v_q || out_ready;
    v_d      = v_q;
    id_d     = id_q;
    val_d    = val_q;
    if (load) begin
      v_d   = 1'b1;
      id_d  = load_id;
      val_d = load_val;
    end else if (out_ready) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      id_q  <= '0;
      val_q <= '0;
    end else begin
      v_q   <= v_d;
      id_q  <= id_d;
      val_q <= val_d;
    end
  end

  assign out_valid = v_q;
  assign out_id    = id_q;
  assign out_val   = val_q;

endmodule

// File: rtl/spmv_network_node.sv
// Two-lane merge node: equal ids are summed onto the centre-facing lane,
// otherwise each lane passes through its own output register.
module spmv_network_node
  import spmv_pkg::*;
#(
  parameter int ID_WIDTH    = 16,
  parameter int VAL_WIDTH   = 32,
  parameter int GROW        = 1,
  parameter int SATURATE    = 0,
  parameter int LOCATION    = 3,
  parameter int PARALLELISM = 50,
  parameter int CNT_WIDTH   = 16,
  localparam int OUT_WIDTH  = VAL_WIDTH + GROW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_a_valid,
  output logic                 in_a_ready,
  input  logic [ID_WIDTH-1:0]  in_a_id,
  input  logic [VAL_WIDTH-1:0] in_a_val,
  input  logic                 in_b_valid,
  output logic                 in_b_ready,
  input  logic [ID_WIDTH-1:0]  in_b_id,
  input  logic [VAL_WIDTH-1:0] in_b_val,
  output logic                 out_a_valid,
  input  logic                 out_a_ready,
  output logic [ID_WIDTH-1:0]  out_a_id,
  output logic [OUT_WIDTH-1:0] out_a_val,
  output logic                 out_b_valid,
  input  logic                 out_b_ready,
  output logic [ID_WIDTH-1:0]  out_b_id,
  output logic [OUT_WIDTH-1:0] out_b_val,
  input  logic                 merge_clr,
  output logic [CNT_WIDTH-1:0] merge_cnt
);

  localparam logic TO_A = towards_center(LOCATION, PARALLELISM);

  logic                        can_a, can_b, can_tgt, match, merge_fire;
  logic                        load_a, load_b;
  logic [ID_WIDTH-1:0]         load_b_id;
  logic signed [OUT_WIDTH-1:0] a_ext, b_ext, merged_val;
  logic [OUT_WIDTH-1:0]        load_a_val, load_b_val;
  logic [CNT_WIDTH-1:0]        merge_cnt_q, merge_cnt_d;

  always_comb begin
    a_ext = OUT_WIDTH'($signed(in_a_val));
    b_ext = OUT_WIDTH'($signed(in_b_val));
    if (SATURATE != 0 && GROW == 0) begin
      merged_val = OUT_WIDTH'(sat_add(MAX_W'($signed(in_a_val)),
                                      MAX_W'($signed(in_b_val)), OUT_WIDTH));
    end else begin
      merged_val = a_ext + b_ext;
    end
  end

  // Ready depends on the inputs only through the id match, never on values.
  always_comb begin
    match      = in_a_valid && in_b_valid && (in_a_id == in_b_id);
    can_tgt    = TO_A ? can_a : can_b;
    in_a_ready = can_a;
    in_b_ready = can_b;
    load_a     = in_a_valid && can_a;
    load_b     = in_b_valid && can_b;
    load_a_val = a_ext;
    load_b_val = b_ext;
    load_b_id  = in_b_id;
    merge_fire = 1'b0;
    if (match) begin
      in_a_ready = can_tgt;
      in_b_ready = can_tgt;
      merge_fire = can_tgt;
      load_a     = TO_A && can_tgt;
      load_b     = !TO_A && can_tgt;
      if (TO_A) begin
        load_a_val = merged_val;
      end else begin
        load_b_val = merged_val;
        load_b_id  = in_a_id;
      end
    end
  end

  always_comb begin
    merge_cnt_d = merge_cnt_q;
    if (merge_clr) begin
      merge_cnt_d = '0;
    end else if (merge_fire && !(&merge_cnt_q)) begin
      merge_cnt_d = merge_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      merge_cnt_q <= '0;
    end else begin
      merge_cnt_q <= merge_cnt_d;
    end
  end

  assign merge_cnt = merge_cnt_q;

  spmv_out_reg #(.ID_WIDTH(ID_WIDTH), .VAL_WIDTH(OUT_WIDTH)) u_reg_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_a),
    .load_id   (in_a_id),
    .load_val  (load_a_val),
    .out_ready (out_a_ready),
    .can_load  (can_a),
    .out_valid (out_a_valid),
    .out_id    (out_a_id),
    .out_val   (out_a_val)
  );

  spmv_out_reg #(.ID_WIDTH(ID_WIDTH), .VAL_WIDTH(OUT_WIDTH)) u_reg_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_b),
    .load_id   (load_b_id),
    .load_val  (load_b_val),
    .out_ready (out_b_ready),
    .can_load  (can_b),
    .out_valid (out_b_valid),
    .out_id    (out_b_id),
    .out_val   (out_b_val)
  );

endmodule

// File: tb/tb_spmv_network_node.sv
// Directed bench: three node configurations (target A, target B, 8-bit saturating
// with a 2-bit counter) share one set of input drivers.
module tb_spmv_network_node;

  logic        clk;
  logic        rst_n;
  logic        in_a_valid, in_b_valid, out_a_ready, out_b_ready, merge_clr;
  logic [15:0] in_a_id, in_b_id;
  logic [31:0] in_a_val, in_b_val;

  logic        c_in_a_ready, c_in_b_ready, c_out_a_valid, c_out_b_valid;
  logic [15:0] c_out_a_id, c_out_b_id, c_merge_cnt;
  logic [32:0] c_out_a_val, c_out_b_val;

  logic        e_in_a_ready, e_in_b_ready, e_out_a_valid, e_out_b_valid;
  logic [15:0] e_out_a_id, e_out_b_id, e_merge_cnt;
  logic [32:0] e_out_a_val, e_out_b_val;

  logic        s_in_a_ready, s_in_b_ready, s_out_a_valid, s_out_b_valid;
  logic [15:0] s_out_a_id, s_out_b_id;
  logic [7:0]  s_out_a_val, s_out_b_val;
  logic [1:0]  s_merge_cnt;

  int n_pass = 0;
  int n_total = 0;

  spmv_network_node #(.LOCATION(30), .PARALLELISM(50)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_a_valid(in_a_valid), .in_a_ready(c_in_a_ready), .in_a_id(in_a_id), .in_a_val(in_a_val),
    .in_b_valid(in_b_valid), .in_b_ready(c_in_b_ready), .in_b_id(in_b_id), .in_b_val(in_b_val),
    .out_a_valid(c_out_a_valid), .out_a_ready(out_a_ready), .out_a_id(c_out_a_id), .out_a_val(c_out_a_val),
    .out_b_valid(c_out_b_valid), .out_b_ready(out_b_ready), .out_b_id(c_out_b_id), .out_b_val(c_out_b_val),
    .merge_clr(merge_clr), .merge_cnt(c_merge_cnt)
  );

  spmv_network_node #(.LOCATION(3), .PARALLELISM(50)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .in_a_valid(in_a_valid), .in_a_ready(e_in_a_ready), .in_a_id(in_a_id), .in_a_val(in_a_val),
    .in_b_valid(in_b_valid), .in_b_ready(e_in_b_ready), .in_b_id(in_b_id), .in_b_val(in_b_val),
    .out_a_valid(e_out_a_valid), .out_a_ready(out_a_ready), .out_a_id(e_out_a_id), .out_a_val(e_out_a_val),
    .out_b_valid(e_out_b_valid), .out_b_ready(out_b_ready), .out_b_id(e_out_b_id), .out_b_val(e_out_b_val),
    .merge_clr(merge_clr), .merge_cnt(e_merge_cnt)
  );

  spmv_network_node #(.VAL_WIDTH(8), .GROW(0), .SATURATE(1), .LOCATION(30), .PARALLELISM(50),
                      .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_a_valid(in_a_valid), .in_a_ready(s_in_a_ready), .in_a_id(in_a_id), .in_a_val(in_a_val[7:0]),
    .in_b_valid(in_b_valid), .in_b_ready(s_in_b_ready), .in_b_id(in_b_id), .in_b_val(in_b_val[7:0]),
    .out_a_valid(s_out_a_valid), .out_a_ready(out_a_ready), .out_a_id(s_out_a_id), .out_a_val(s_out_a_val),
    .out_b_valid(s_out_b_valid), .out_b_ready(out_b_ready), .out_b_id(s_out_b_id), .out_b_val(s_out_b_val),
    .merge_clr(merge_clr), .merge_cnt(s_merge_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000 ns");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_a_valid  = 1'b0;
    in_b_valid  = 1'b0;
    in_a_id     = '0;
    in_b_id     = '0;
    in_a_val    = '0;
    in_b_val    = '0;
    merge_clr   = 1'b0;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_a(input logic [15:0] id, input logic [31:0] val);
    in_a_valid = 1'b1;
    in_a_id    = id;
    in_a_val   = val;
  endtask

  task automatic drive_b(input logic [15:0] id, input logic [31:0] val);
    in_b_valid = 1'b1;
    in_b_id    = id;
    in_b_val   = val;
  endtask

  // Scenarios
  task automatic test_reset();
    idle();
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_total++; if (c_out_a_valid !== 1'b0) $display("FAIL reset_out_a_valid got=%0h want=0", c_out_a_valid); else n_pass++;
    n_total++; if (c_out_b_valid !== 1'b0) $display("FAIL reset_out_b_valid got=%0h want=0", c_out_b_valid); else n_pass++;
    n_total++; if (c_out_a_id !== 16'd0) $display("FAIL reset_out_a_id got=%0h want=0", c_out_a_id); else n_pass++;
    n_total++; if (c_out_a_val !== 33'd0) $display("FAIL reset_out_a_val got=%0h want=0", c_out_a_val); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd0) $display("FAIL reset_merge_cnt got=%0h want=0", c_merge_cnt); else n_pass++;
    n_total++; if (c_in_a_ready !== 1'b1) $display("FAIL reset_in_a_ready got=%0h want=1", c_in_a_ready); else n_pass++;
    n_total++; if (c_in_b_ready !== 1'b1) $display("FAIL reset_in_b_ready got=%0h want=1", c_in_b_ready); else n_pass++;
    n_total++; if (s_merge_cnt !== 2'd0) $display("FAIL reset_s_merge_cnt got=%0h want=0", s_merge_cnt); else n_pass++;
    idle();
  endtask

  task automatic test_merge_toward_a();
    do_reset();
    drive_a(16'd7, 32'd5);
    drive_b(16'd7, 32'hffff_fffd);
    #1;
    n_total++; if (c_in_a_ready !== 1'b1) $display("FAIL merge_a_in_a_ready got=%0h want=1", c_in_a_ready); else n_pass++;
    n_total++; if (c_in_b_ready !== 1'b1) $display("FAIL merge_a_in_b_ready got=%0h want=1", c_in_b_ready); else n_pass++;
    tick();
    drive_a(16'd8, 32'h7fff_ffff);
    drive_b(16'd8, 32'h7fff_ffff);
    n_total++; if (c_out_a_valid !== 1'b1) $display("FAIL merge_a_valid got=%0h want=1", c_out_a_valid); else n_pass++;
    n_total++; if (c_out_a_id !== 16'd7) $display("FAIL merge_a_id got=%0h want=7", c_out_a_id); else n_pass++;
    n_total++; if (c_out_a_val !== 33'd2) $display("FAIL merge_a_val got=%0h want=2", c_out_a_val); else n_pass++;
    n_total++; if (c_out_b_valid !== 1'b0) $display("FAIL merge_a_b_valid got=%0h want=0", c_out_b_valid); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd1) $display("FAIL merge_a_cnt got=%0h want=1", c_merge_cnt); else n_pass++;
    tick();
    idle();
    n_total++; if (c_out_a_id !== 16'd8) $display("FAIL merge_a_b2b_id got=%0h want=8", c_out_a_id); else n_pass++;
    n_total++; if (c_out_a_val !== 33'h0_ffff_fffe) $display("FAIL merge_a_grow_val got=%0h want=fffffffe", c_out_a_val); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd2) $display("FAIL merge_a_b2b_cnt got=%0h want=2", c_merge_cnt); else n_pass++;
    tick();
    n_total++; if (c_out_a_valid !== 1'b0) $display("FAIL merge_a_drain got=%0h want=0", c_out_a_valid); else n_pass++;
  endtask

  task automatic test_merge_toward_b();
    do_reset();
    drive_a(16'd4, 32'd10);
    drive_b(16'd4, 32'd20);
    tick();
    idle();
    n_total++; if (e_out_b_valid !== 1'b1) $display("FAIL merge_b_valid got=%0h want=1", e_out_b_valid); else n_pass++;
    n_total++; if (e_out_b_id !== 16'd4) $display("FAIL merge_b_id got=%0h want=4", e_out_b_id); else n_pass++;
    n_total++; if (e_out_b_val !== 33'd30) $display("FAIL merge_b_val got=%0h want=1e", e_out_b_val); else n_pass++;
    n_total++; if (e_out_a_valid !== 1'b0) $display("FAIL merge_b_a_valid got=%0h want=0", e_out_a_valid); else n_pass++;
    n_total++; if (e_merge_cnt !== 16'd1) $display("FAIL merge_b_cnt got=%0h want=1", e_merge_cnt); else n_pass++;
  endtask

  task automatic test_pass_through();
    do_reset();
    drive_a(16'd1, 32'd100);
    drive_b(16'd2, 32'hffff_ffff);
    tick();
    idle();
    n_total++; if (c_out_a_valid !== 1'b1) $display("FAIL pass_a_valid got=%0h want=1", c_out_a_valid); else n_pass++;
    n_total++; if (c_out_a_id !== 16'd1) $display("FAIL pass_a_id got=%0h want=1", c_out_a_id); else n_pass++;
    n_total++; if (c_out_a_val !== 33'd100) $display("FAIL pass_a_val got=%0h want=64", c_out_a_val); else n_pass++;
    n_total++; if (c_out_b_valid !== 1'b1) $display("FAIL pass_b_valid got=%0h want=1", c_out_b_valid); else n_pass++;
    n_total++; if (c_out_b_id !== 16'd2) $display("FAIL pass_b_id got=%0h want=2", c_out_b_id); else n_pass++;
    n_total++; if (c_out_b_val !== 33'h1_ffff_ffff) $display("FAIL pass_b_sext got=%0h want=1ffffffff", c_out_b_val); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd0) $display("FAIL pass_cnt got=%0h want=0", c_merge_cnt); else n_pass++;
  endtask

  task automatic test_backpressure_divergent();
    logic [15:0] exp_id;
    logic [32:0] exp_val;
    do_reset();
    drive_a(16'd6, 32'd1);
    drive_b(16'd5, 32'd77);
    tick();
    out_b_ready = 1'b0;
    drive_b(16'd99, 32'd55);
    for (int i = 0; i < 3; i++) begin
      drive_a(16'(10 + i), 32'(1000 + i));
      exp_id  = 16'(10 + i);
      exp_val = 33'(1000 + i);
      #1;
      n_total++; if (c_in_a_ready !== 1'b1) $display("FAIL bp_div_in_a_ready[%0d] got=%0h want=1", i, c_in_a_ready); else n_pass++;
      n_total++; if (c_in_b_ready !== 1'b0) $display("FAIL bp_div_in_b_ready[%0d] got=%0h want=0", i, c_in_b_ready); else n_pass++;
      tick();
      n_total++; if (c_out_a_id !== exp_id) $display("FAIL bp_div_a_id[%0d] got=%0h want=%0h", i, c_out_a_id, exp_id); else n_pass++;
      n_total++; if (c_out_a_val !== exp_val) $display("FAIL bp_div_a_val[%0d] got=%0h want=%0h", i, c_out_a_val, exp_val); else n_pass++;
      n_total++; if (c_out_b_id !== 16'd5) $display("FAIL bp_div_b_hold_id[%0d] got=%0h want=5", i, c_out_b_id); else n_pass++;
      n_total++; if (c_out_b_val !== 33'd77) $display("FAIL bp_div_b_hold_val[%0d] got=%0h want=4d", i, c_out_b_val); else n_pass++;
      n_total++; if (c_out_b_valid !== 1'b1) $display("FAIL bp_div_b_valid[%0d] got=%0h want=1", i, c_out_b_valid); else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure_merge();
    do_reset();
    drive_a(16'd3, 32'd1);
    tick();
    out_a_ready = 1'b0;
    drive_a(16'd8, 32'd5);
    drive_b(16'd8, 32'd6);
    #1;
    n_total++; if (c_in_a_ready !== 1'b0) $display("FAIL bp_merge_in_a_ready got=%0h want=0", c_in_a_ready); else n_pass++;
    n_total++; if (c_in_b_ready !== 1'b0) $display("FAIL bp_merge_in_b_ready got=%0h want=0", c_in_b_ready); else n_pass++;
    tick();
    n_total++; if (c_out_a_id !== 16'd3) $display("FAIL bp_merge_hold_id got=%0h want=3", c_out_a_id); else n_pass++;
    n_total++; if (c_out_a_val !== 33'd1) $display("FAIL bp_merge_hold_val got=%0h want=1", c_out_a_val); else n_pass++;
    n_total++; if (c_out_b_valid !== 1'b0) $display("FAIL bp_merge_b_valid got=%0h want=0", c_out_b_valid); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd0) $display("FAIL bp_merge_cnt_stable got=%0h want=0", c_merge_cnt); else n_pass++;
    out_a_ready = 1'b1;
    #1;
    n_total++; if (c_in_b_ready !== 1'b1) $display("FAIL bp_merge_release_ready got=%0h want=1", c_in_b_ready); else n_pass++;
    tick();
    idle();
    n_total++; if (c_out_a_id !== 16'd8) $display("FAIL bp_merge_after_id got=%0h want=8", c_out_a_id); else n_pass++;
    n_total++; if (c_out_a_val !== 33'd11) $display("FAIL bp_merge_after_val got=%0h want=b", c_out_a_val); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd1) $display("FAIL bp_merge_after_cnt got=%0h want=1", c_merge_cnt); else n_pass++;
  endtask

  task automatic test_saturate_counter();
    do_reset();
    drive_a(16'd9, 32'd100);
    drive_b(16'd9, 32'd100);
    tick();
    n_total++; if (s_out_a_id !== 16'd9) $display("FAIL sat_id got=%0h want=9", s_out_a_id); else n_pass++;
    n_total++; if (s_out_a_val !== 8'h7f) $display("FAIL sat_pos got=%0h want=7f", s_out_a_val); else n_pass++;
    n_total++; if (s_merge_cnt !== 2'd1) $display("FAIL sat_cnt1 got=%0h want=1", s_merge_cnt); else n_pass++;
    drive_a(16'd9, 32'hffff_ff9c);
    drive_b(16'd9, 32'hffff_ff9c);
    tick();
    n_total++; if (s_out_a_val !== 8'h80) $display("FAIL sat_neg got=%0h want=80", s_out_a_val); else n_pass++;
    n_total++; if (s_merge_cnt !== 2'd2) $display("FAIL sat_cnt2 got=%0h want=2", s_merge_cnt); else n_pass++;
    drive_a(16'd9, 32'd1);
    drive_b(16'd9, 32'd1);
    tick();
    n_total++; if (s_out_a_val !== 8'd2) $display("FAIL sat_small got=%0h want=2", s_out_a_val); else n_pass++;
    n_total++; if (s_merge_cnt !== 2'd3) $display("FAIL sat_cnt3 got=%0h want=3", s_merge_cnt); else n_pass++;
    drive_b(16'd9, 32'd2);
    tick();
    n_total++; if (s_out_a_val !== 8'd3) $display("FAIL sat_small2 got=%0h want=3", s_out_a_val); else n_pass++;
    n_total++; if (s_merge_cnt !== 2'd3) $display("FAIL cnt_saturates got=%0h want=3", s_merge_cnt); else n_pass++;
    drive_a(16'd9, 32'd5);
    drive_b(16'd9, 32'd5);
    merge_clr = 1'b1;
    tick();
    idle();
    n_total++; if (s_merge_cnt !== 2'd0) $display("FAIL clr_priority got=%0h want=0", s_merge_cnt); else n_pass++;
    n_total++; if (s_out_a_val !== 8'd10) $display("FAIL clr_merge_val got=%0h want=a", s_out_a_val); else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    drive_a(16'd1, 32'd1);
    drive_b(16'd1, 32'd1);
    tick();
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    drive_a(16'd2, 32'd2);
    drive_b(16'd3, 32'd3);
    tick();
    n_total++; if (c_out_a_valid !== 1'b1) $display("FAIL mid_pre_a_valid got=%0h want=1", c_out_a_valid); else n_pass++;
    n_total++; if (c_out_a_id !== 16'd1) $display("FAIL mid_pre_a_id got=%0h want=1", c_out_a_id); else n_pass++;
    n_total++; if (c_out_b_id !== 16'd3) $display("FAIL mid_pre_b_id got=%0h want=3", c_out_b_id); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd1) $display("FAIL mid_pre_cnt got=%0h want=1", c_merge_cnt); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++; if (c_out_a_valid !== 1'b0) $display("FAIL mid_a_valid got=%0h want=0", c_out_a_valid); else n_pass++;
    n_total++; if (c_out_b_valid !== 1'b0) $display("FAIL mid_b_valid got=%0h want=0", c_out_b_valid); else n_pass++;
    n_total++; if (c_out_b_id !== 16'd0) $display("FAIL mid_b_id got=%0h want=0", c_out_b_id); else n_pass++;
    n_total++; if (c_out_b_val !== 33'd0) $display("FAIL mid_b_val got=%0h want=0", c_out_b_val); else n_pass++;
    n_total++; if (c_merge_cnt !== 16'd0) $display("FAIL mid_cnt got=%0h want=0", c_merge_cnt); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (c_in_a_ready !== 1'b1) $display("FAIL mid_post_ready got=%0h want=1", c_in_a_ready); else n_pass++;
    idle();
    tick();
  endtask

  // Sequence and final report
  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_merge_toward_a();
    test_merge_toward_b();
    test_pass_through();
    test_backpressure_divergent();
    test_backpressure_merge();
    test_saturate_counter();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
